// File: rtl/aes_pkg.sv
// Shared AES-128 key schedule definitions:
// S-box table, xtime, round constants, FSM state encodings.
package aes_pkg;

  localparam int AES_NUM_ROUNDS = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic {
    ST_IDLE,
    ST_EXPAND
  } state_t;

  // Byte 0 of the table sits in the top byte
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [10:0] base;
    base = {~a, 3'b000};
    return SBOX_TABLE[base +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four independent
// S-box lookups on a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);

  assign sub = {sbox(word[31:24]),
                sbox(word[23:16]),
                sbox(word[15:8]),
                sbox(word[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: expands one cipher key
// into 11 round keys, one per cycle, into a buffer.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [127:0]     key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic             busy,
  output logic             keys_ready,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [127:0]     rd_key
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ROUNDS);

  state_t           state;
  logic [IDX_W-1:0] rnd;
  logic [7:0]       rcon;
  logic [31:0]      w0, w1, w2, w3;
  logic [31:0]      sw, t;
  logic [31:0]      n0, n1, n2, n3;
  logic             accept;
  logic [127:0]     rk [0:NUM_ROUNDS];

  assign accept = (state == ST_IDLE) && key_valid && key_ready;

  aes_sub_word u_sub (
    .word ({w3[23:0], w3[31:24]}),
    .sub  (sw)
  );

  assign t  = sw ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  // Control FSM with round counter, rcon and working words
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      key_ready  <= 1'b1;
      busy       <= 1'b0;
      keys_ready <= 1'b0;
      rnd        <= '0;
      rcon       <= RCON_INIT;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            w0         <= key_in[127:96];
            w1         <= key_in[95:64];
            w2         <= key_in[63:32];
            w3         <= key_in[31:0];
            rnd        <= IDX_W'(1);
            rcon       <= RCON_INIT;
            keys_ready <= 1'b0;
            key_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          w0   <= n0;
          w1   <= n1;
          w2   <= n2;
          w3   <= n3;
          rnd  <= rnd + 1'b1;
          rcon <= xtime(rcon);
          if (rnd == LAST) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            key_ready  <= 1'b1;
            keys_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Round-key buffer writes; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept)
        rk[0] <= key_in;
      else if (state == ST_EXPAND)
        rk[rnd] <= {n0, n1, n2, n3};
    end
  end

  // Registered read port, zero for out-of-range index
  always_ff @(posedge clk) begin
    if (rst)
      rd_key <= '0;
    else if (rd_idx <= LAST)
      rd_key <= rk[rd_idx];
    else
      rd_key <= '0;
  end

endmodule
